param_dp_mem: RTL and testbench

- Parametrised dual-port word memory for the MIPS datapath: one synchronous write port and one read port.
- Adds the following over the fixed 4096x32 distributed-RAM wrapper:
  - per-byte write strobes;
  - selectable read latency, 0 (combinational) or 1 (registered);
  - read-during-write forwarding;
  - hardware clear sequencer that zeroes the whole array after reset or on request.
- Serves as the data memory, and as the instruction memory with BE tied to all-ones.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_clear_seq.sv | 58 +++++
 rtl/param_dp_mem.sv | 97 +++++++++
 tb/tb_param_dp_mem.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised dual-port word memory.
package mem_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   localparam int unsigned RD_LAT_COMB = 0;
   localparam int unsigned RD_LAT_REG  = 1;

   function automatic int unsigned nlanes(input int unsigned dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Clear sequencer: sweeps every word to zero after reset or on clr_req.
module mem_clear_seq
   import mem_pkg::*;
#(
   parameter int unsigned AW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          busy,
   output logic          clr_we,
   output logic [AW-1:0] clr_a
);

   clr_state_t    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            // clr_req is deliberately not looked at here: a sweep is never restarted
            if (cnt_q == '1) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy   = (state_q == CLEAR);
   assign clr_we = busy;
   assign clr_a  = cnt_q;

endmodule

// File: rtl/param_dp_mem.sv
// Parametrised dual-port word memory: byte-strobed synchronous write,
// 0/1-cycle read latency with optional write forwarding, hardware clear.
module param_dp_mem
   import mem_pkg::*;
#(
   parameter int unsigned AW     = 12,
   parameter int unsigned DW     = 32,
   parameter int unsigned RD_LAT = 0,
   parameter int unsigned WR_FWD = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [DW/8-1:0]       be,
   input  logic [AW-1:0]         a,
   input  logic [DW-1:0]         d,
   input  logic [AW-1:0]         dpra,
   output logic [DW-1:0]         dpo,
   input  logic                  clr_req,
   output logic                  busy
);

   localparam int unsigned DEPTH = 2 ** AW;
   localparam int unsigned NL    = nlanes(DW);

   if ((DW % 8) != 0) begin : g_dw_check
      $error("param_dp_mem: DW must be a multiple of 8");
   end
   if ((RD_LAT != RD_LAT_COMB) && (RD_LAT != RD_LAT_REG)) begin : g_lat_check
      $error("param_dp_mem: RD_LAT must be 0 or 1");
   end

   logic [DW-1:0] mem [DEPTH];

   logic          clr_we;
   logic [AW-1:0] clr_a;

   mem_clear_seq #(.AW(AW)) u_clr (
      .clk     (clk),
      .rst     (rst),
      .clr_req (clr_req),
      .busy    (busy),
      .clr_we  (clr_we),
      .clr_a   (clr_a)
   );

   // The sweep owns the write port while busy; user writes are dropped, not queued.
   logic [AW-1:0] wr_a;
   logic [DW-1:0] wr_d;
   logic [NL-1:0] wr_be;

   always_comb begin
      wr_a  = a;
      wr_d  = d;
      wr_be = we ? be : '0;
      if (clr_we) begin
         wr_a  = clr_a;
         wr_d  = '0;
         wr_be = '1;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NL; i++) begin
         if (wr_be[i]) mem[wr_a][8*i +: 8] <= wr_d[8*i +: 8];
      end
   end

   if (RD_LAT == RD_LAT_REG) begin : g_rd_reg
      logic [DW-1:0] merged;
      logic [DW-1:0] dpo_q;

      always_comb begin
         merged = mem[dpra];
         for (int unsigned i = 0; i < NL; i++) begin
            if (be[i]) merged[8*i +: 8] = d[8*i +: 8];
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dpo_q <= '0;
         end else if (busy) begin
            dpo_q <= '0;
         end else if ((WR_FWD != 0) && we && (a == dpra)) begin
            dpo_q <= merged;
         end else begin
            dpo_q <= mem[dpra];
         end
      end

      assign dpo = dpo_q;
   end else begin : g_rd_comb
      assign dpo = busy ? '0 : mem[dpra];
   end

endmodule

// File: tb/tb_param_dp_mem.sv
// Randomised bench for param_dp_mem: three instances (comb, reg+fwd, reg no-fwd)
// share stimulus and are checked against an array-based reference model.
module tb_param_dp_mem;

   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          we;
   logic [3:0]    be;
   logic [AW-1:0] a;
   logic [DW-1:0] d;
   logic [AW-1:0] dpra;
   logic          clr_req;
   logic [DW-1:0] dpo0, dpo1, dpo2;
   logic          busy0, busy1, busy2;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] ref_mem [DEPTH];
   int          sweep_left;
   logic [31:0] exp1, exp2;

   always #5 clk = ~clk;

   param_dp_mem #(.AW(AW), .DW(DW), .RD_LAT(0), .WR_FWD(1)) u_comb (
      .clk(clk), .rst(rst), .we(we), .be(be), .a(a), .d(d), .dpra(dpra),
      .dpo(dpo0), .clr_req(clr_req), .busy(busy0)
   );
   param_dp_mem #(.AW(AW), .DW(DW), .RD_LAT(1), .WR_FWD(1)) u_fwd (
      .clk(clk), .rst(rst), .we(we), .be(be), .a(a), .d(d), .dpra(dpra),
      .dpo(dpo1), .clr_req(clr_req), .busy(busy1)
   );
   param_dp_mem #(.AW(AW), .DW(DW), .RD_LAT(1), .WR_FWD(0)) u_nofwd (
      .clk(clk), .rst(rst), .we(we), .be(be), .a(a), .d(d), .dpra(dpra),
      .dpo(dpo2), .clr_req(clr_req), .busy(busy2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic bsy;
      bsy = (sweep_left != 0);
      check("busy0", {31'd0, busy0}, {31'd0, bsy});
      check("busy1", {31'd0, busy1}, {31'd0, bsy});
      check("busy2", {31'd0, busy2}, {31'd0, bsy});
      check("dpo0", dpo0, bsy ? 32'd0 : ref_mem[dpra]);
      check("dpo1", dpo1, exp1);
      check("dpo2", dpo2, exp2);
   endtask

   // One clock edge: model captures pre-edge inputs, then commits after the edge.
   task automatic step();
      logic [31:0] old_w, merged;
      logic        bsy;
      #2;
      bsy = (sweep_left != 0);
      check("dpo0_pre", dpo0, bsy ? 32'd0 : ref_mem[dpra]);
      old_w  = ref_mem[dpra];
      merged = ref_mem[a];
      for (int i = 0; i < 4; i++) if (be[i]) merged[8*i +: 8] = d[8*i +: 8];
      @(posedge clk);
      #1;
      if (bsy) begin
         exp1 = 32'd0;
         exp2 = 32'd0;
         sweep_left--;
      end else begin
         exp2 = old_w;
         exp1 = (we && a == dpra) ? merged : old_w;
         if (we) ref_mem[a] = merged;
         if (clr_req) begin
            sweep_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
         end
      end
      check_outputs();
   endtask

   task automatic idle_inputs();
      we = 1'b0; be = 4'h0; a = '0; d = '0; clr_req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      sweep_left = DEPTH;
      exp1 = 32'd0;
      exp2 = 32'd0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
      check_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_sweep(input string tag);
      int n;
      n = 0;
      while (busy0 === 1'b1 && n < 40) begin
         step();
         n++;
      end
      check(tag, n, DEPTH);
   endtask

   task automatic wr(input logic [3:0] aa, input logic [31:0] dd, input logic [3:0] bb);
      we = 1'b1; a = aa; d = dd; be = bb;
      step();
      we = 1'b0; be = 4'h0;
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         dpra = 4'(i);
         step();
         check(tag, dpo0, 32'd0);
         check(tag, dpo1, 32'd0);
      end
   endtask

   initial begin
      idle_inputs();
      dpra = '0;
      rst  = 1'b1;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
      sweep_left = DEPTH;
      exp1 = 32'd0;
      exp2 = 32'd0;
      #1;
      check_outputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_sweep("sweep_len_por");
      read_all_zero("por_zero");

      // Pre-fill, then reset and expect a full clean sweep.
      for (int i = 0; i < DEPTH; i++) wr(4'(i), 32'hDEADBEEF, 4'hF);
      dpra = 4'd7;
      step();
      check("prefill", dpo0, 32'hDEADBEEF);
      do_reset();
      run_sweep("sweep_len_rst");
      read_all_zero("rst_zero");

      // Byte strobes and read latency.
      wr(4'd3, 32'h11223344, 4'hF);
      wr(4'd3, 32'hAABBCCDD, 4'h5);
      dpra = 4'd3;
      #2;
      check("lat0_same_cycle", dpo0, 32'h11BB33DD);
      step();
      check("lat1_after_edge", dpo1, 32'h11BB33DD);

      // Collision on a cleared word.
      wr(4'd5, 32'h0, 4'hF);
      dpra = 4'd5;
      we = 1'b1; a = 4'd5; d = 32'hFFFFFFFF; be = 4'h3;
      step();
      we = 1'b0; be = 4'h0;
      check("coll_fwd", dpo1, 32'h0000FFFF);
      check("coll_nofwd", dpo2, 32'h00000000);
      check("coll_comb_after", dpo0, 32'h0000FFFF);

      // Busy lockout with an ignored second clr_req.
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      begin
         int n;
         n = 0;
         while (busy0 === 1'b1 && n < 40) begin
            we = 1'b1; a = 4'd2; d = 32'h12345678; be = 4'hF; dpra = 4'd2;
            clr_req = (n == 5);
            step();
            check("lockout_dpo", dpo0, 32'd0);
            n++;
         end
         check("sweep_len_clr", n, DEPTH);
      end
      idle_inputs();
      dpra = 4'd2;
      step();
      check("lockout_mem2", dpo0, 32'd0);

      // Reset in the middle of a sweep.
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (9) step();
      do_reset();
      run_sweep("sweep_len_mid");
      read_all_zero("mid_zero");

      // Random traffic with rare clear requests.
      for (int k = 0; k < 600; k++) begin
         we      = $urandom_range(0, 1) == 1;
         be      = 4'($urandom);
         a       = 4'($urandom);
         d       = $urandom;
         dpra    = ($urandom_range(0, 3) == 0) ? a : 4'($urandom);
         clr_req = ($urandom_range(0, 59) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
